// File: rtl/bus_pkg.sv
// bus_pkg
//   Shared definitions for the datapath bus driver.
//   bus_mode_t : arbitration mode used when more than one source gates the bus
//   BUS_W      : default bus / source data width
//   CNT_MAX    : saturation value of the conflict counter
package bus_pkg;

   typedef enum logic [1:0] {
      BM_STRICT,
      BM_PRIORITY,
      BM_RR
   } bus_mode_t;

   localparam int         BUS_W   = 16;
   localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a registered last-grant pointer.
//   Clk   : clock, rising edge
//   Reset : synchronous active-high reset, ptr <= N-1 so the first search
//           begins at index 0
//   req   : per-source request vector
//   grant : combinational one-hot grant (all zero when no request)
//   ptr   : index of the most recent grant; holds when nothing is granted
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] ptr
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] grant_idx;
   logic          found;

   // Search starts one past the last winner and wraps, so every requester
   // is reached within N grants.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!found && req[(int'(ptr) + k) % N]) begin
            found                         = 1'b1;
            grant[(int'(ptr) + k) % N]    = 1'b1;
            grant_idx                     = PW'((int'(ptr) + k) % N);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ptr <= PW'(N - 1);
      end else if (found) begin
         ptr <= grant_idx;
      end
   end

endmodule

// File: rtl/bus_gate_mux.sv
// bus_gate_mux
//   Registered bus driver: selects one of NSRC gated sources onto the
//   shared bus, with strict / priority / round-robin arbitration and a
//   saturating conflict counter for debug.
//   Clk           : clock, rising edge
//   Reset         : synchronous active-high reset, clears all outputs
//   Din           : packed source array, Din[i] is source i
//   Gate          : per-source gate request
//   ClearCount    : synchronous clear of ConflictCount (wins over increment)
//   Q             : registered bus value (0 when nothing granted)
//   Valid         : Q carries a granted source
//   Src           : granted source index (0 when Valid is low)
//   Conflict      : one-cycle pulse per cycle where more than one Gate bit was set
//   ConflictCount : saturating count of conflict cycles
//
// Handshake: there is no ready/backpressure. A selection is taken every
// cycle; Valid qualifies Q/Src for exactly the cycle after the edge that
// sampled Gate, and consumers must take it in that cycle.
module bus_gate_mux
   import bus_pkg::*;
#(
   parameter int        WIDTH = BUS_W,
   parameter int        NSRC  = 4,
   parameter bus_mode_t MODE  = BM_STRICT
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [NSRC-1:0][WIDTH-1:0] Din,
   input  logic [NSRC-1:0]            Gate,
   input  logic                       ClearCount,
   output logic [WIDTH-1:0]           Q,
   output logic                       Valid,
   output logic [$clog2(NSRC)-1:0]    Src,
   output logic                       Conflict,
   output logic [7:0]                 ConflictCount
);

   localparam int SW = $clog2(NSRC);

   logic            any_gate;
   logic            multi_gate;
   logic [SW-1:0]   low_idx;
   logic [NSRC-1:0] rr_grant;
   logic [SW-1:0]   rr_idx;
   logic            sel_valid;
   logic [SW-1:0]   sel_idx;

   assign any_gate   = |Gate;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_gate = |(Gate & (Gate - NSRC'(1)));

   always_comb begin
      low_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (Gate[i]) low_idx = SW'(i);
      end
   end

   if (MODE == BM_RR) begin : g_rr
      logic [SW-1:0] rr_ptr;
      logic          unused_rr_ptr;

      rr_arbiter #(.N(NSRC)) u_rr (
         .Clk   (Clk),
         .Reset (Reset),
         .req   (Gate),
         .grant (rr_grant),
         .ptr   (rr_ptr)
      );

      // The pointer lives inside the arbiter; the top only needs the grant.
      assign unused_rr_ptr = ^rr_ptr;

      always_comb begin
         rr_idx = '0;
         for (int i = 0; i < NSRC; i++) begin
            if (rr_grant[i]) rr_idx = SW'(i);
         end
      end
   end else begin : g_no_rr
      assign rr_grant = '0;
      assign rr_idx   = '0;
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      if (MODE == BM_RR) begin
         sel_valid = |rr_grant;
         sel_idx   = rr_idx;
      end else if (MODE == BM_PRIORITY) begin
         sel_valid = any_gate;
         sel_idx   = low_idx;
      end else begin
         sel_valid = any_gate && !multi_gate;
         sel_idx   = low_idx;
      end
      if (!sel_valid) sel_idx = '0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Q             <= '0;
         Valid         <= 1'b0;
         Src           <= '0;
         Conflict      <= 1'b0;
         ConflictCount <= '0;
      end else begin
         Q        <= sel_valid ? Din[sel_idx] : '0;
         Valid    <= sel_valid;
         Src      <= sel_idx;
         Conflict <= multi_gate;
         if (ClearCount) begin
            ConflictCount <= '0;
         end else if (multi_gate && ConflictCount != CNT_MAX) begin
            ConflictCount <= ConflictCount + 8'd1;
         end
      end
   end

endmodule
